// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with programmable duty cycle and a period-start strobe.
// Optional build macro CLK_DIV_RESYNC_EN adds a `resync` input that forces an immediate period restart.
module clk_div_prog #(
  parameter int unsigned      CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV  = CNT_W'(100),
  parameter logic [CNT_W-1:0] DEFAULT_HIGH = CNT_W'(50)
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_tick
`ifdef CLK_DIV_RESYNC_EN
  ,
  input  logic             resync
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] shd_div_q, shd_div_d;
  logic [CNT_W-1:0] shd_high_q, shd_high_d;
  logic             clk_out_q, clk_out_d;
  logic             period_tick_q, period_tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic resync_i;
  logic offer, cfg_ok, accept, wrap, apply_shadow;

`ifdef CLK_DIV_RESYNC_EN
  assign resync_i = resync;
`else
  assign resync_i = 1'b0;
`endif

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = IDLE; else if (accept) state_d = PEND;
      PEND:    if (!en || wrap) state_d = en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cfg_ready = (state_q != PEND);
  end

  always_comb begin
    offer  = cfg_valid && cfg_ready;
    cfg_ok = (cfg_div >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_div);
    accept = offer && cfg_ok;
    // A resync in IDLE is harmless here: the counter is forced to zero whenever not running.
    wrap   = (cnt_q == div_q - CNT_W'(1)) || resync_i;
  end

  // Datapath next values.
  // NOTE: every variable gets a default before any branch, so no latch can be inferred.
  always_comb begin
    div_d        = div_q;
    high_d       = high_q;
    shd_div_d    = shd_div_q;
    shd_high_d   = shd_high_q;
    cfg_err_d    = offer && !cfg_ok;
    apply_shadow = (state_q == PEND) && (!en || wrap);

    // accept is never true in PEND, so the shadow transfer and a fresh offer never collide.
    if (apply_shadow) begin
      div_d  = shd_div_q;
      high_d = shd_high_q;
    end else if (accept && (state_q == IDLE || !en)) begin
      div_d  = cfg_div;
      high_d = cfg_high;
    end else if (accept) begin
      shd_div_d  = cfg_div;
      shd_high_d = cfg_high;
    end

    if (state_q != IDLE && en && !wrap) cnt_d = cnt_q + CNT_W'(1);
    else                                cnt_d = '0;

    clk_out_d     = en && (cnt_d < high_d);
    period_tick_d = en && (cnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      div_q         <= DEFAULT_DIV;
      high_q        <= DEFAULT_HIGH;
      shd_div_q     <= '0;
      shd_high_q    <= '0;
      clk_out_q     <= 1'b0;
      period_tick_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      high_q        <= high_d;
      shd_div_q     <= shd_div_d;
      shd_high_q    <= shd_high_d;
      clk_out_q     <= clk_out_d;
      period_tick_q <= period_tick_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign period_tick = period_tick_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: constant vector table, directed corner sequences,
// and randomized traffic checked against a position-based behavioural model.
module tb_clk_div_prog;

  localparam int W = 32;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;
  logic         cfg_err;
  logic         clk_out;
  logic         period_tick;
  logic         resync;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.CNT_W(W)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .period_tick(period_tick)
`ifdef CLK_DIV_RESYNC_EN
    ,
    .resync     (resync)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: where in the period we are, plus an optional pending config.
  bit              m_run;
  longint unsigned m_pos, m_div, m_high;
  bit              m_pend;
  longint unsigned m_pdiv, m_phigh;
  bit              m_err;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_div = 100; m_high = 50; m_pend = 0; m_err = 0;
  endtask

  // Advance the model by one sys_clk edge using the inputs currently driven.
  task automatic model_edge();
    longint unsigned d = cfg_div;
    longint unsigned h = cfg_high;
    bit offer = cfg_valid && !m_pend;
    bit ok = (d >= 2) && (h >= 1) && (h < d);
    bit acc = offer && ok;
    m_err = offer && !ok;
    if (!m_run) begin
      if (acc) begin m_div = d; m_high = h; end
      if (en) begin m_run = 1; m_pos = 0; end
    end else if (!en) begin
      if (m_pend) begin m_div = m_pdiv; m_high = m_phigh; end
      else if (acc) begin m_div = d; m_high = h; end
      m_pend = 0; m_run = 0; m_pos = 0;
    end else begin
      if (resync || m_pos == m_div - 1) begin
        m_pos = 0;
        if (m_pend) begin m_div = m_pdiv; m_high = m_phigh; m_pend = 0; end
      end else begin
        m_pos++;
      end
      if (acc) begin m_pend = 1; m_pdiv = d; m_phigh = h; end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge sys_clk);
    #1;
    check("clk_out", clk_out, longint'(m_run && m_pos < m_high));
    check("period_tick", period_tick, longint'(m_run && m_pos == 0));
    check("cfg_ready", cfg_ready, longint'(!m_pend));
    check("cfg_err", cfg_err, longint'(m_err));
  endtask

  task automatic offer(input longint unsigned d, input longint unsigned h);
    cfg_valid = 1'b1; cfg_div = W'(d); cfg_high = W'(h);
    step();
    cfg_valid = 1'b0;
  endtask

  // Reset asserted away from a clock edge; outputs must clear without waiting for one.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    en = 1'b0; cfg_valid = 1'b0; resync = 1'b0;
    #1;
    check("async clk_out", clk_out, 0);
    check("async period_tick", period_tick, 0);
    check("async cfg_err", cfg_err, 0);
    check("async cfg_ready", cfg_ready, 1);
    model_reset();
    @(posedge sys_clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic         en;
    logic         valid;
    logic [W-1:0] div;
    logic [W-1:0] high;
    logic         e_clk;
    logic         e_tick;
    logic         e_ready;
    logic         e_err;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic v, input int d, input int h,
                              input logic c, input logic t, input logic r, input logic x);
    vec_t o;
    o.en = e; o.valid = v; o.div = W'(d); o.high = W'(h);
    o.e_clk = c; o.e_tick = t; o.e_ready = r; o.e_err = x;
    return o;
  endfunction

  vec_t vecs[14];

  initial begin
    int tick_idx[$];
    int highs, ticks;
    logic [7:0] pat;

    // Invalid offers, a valid idle load of 4/1, then the 1,0,0,0 pattern.
    vecs[0]  = mk(0, 1, 1, 0, 0, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 1, 8, 8, 0, 0, 1, 1);
    vecs[3]  = mk(0, 1, 4, 0, 0, 0, 1, 1);
    vecs[4]  = mk(0, 1, 4, 1, 0, 0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 1, 1, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 1, 1, 1, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vecs[13] = mk(1, 0, 0, 0, 1, 1, 1, 0);

    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0; resync = 1'b0;
    model_reset();
    #22 rst_n = 1'b1;
    check("reset clk_out", clk_out, 0);
    check("reset period_tick", period_tick, 0);
    check("reset cfg_err", cfg_err, 0);
    check("reset cfg_ready", cfg_ready, 1);

    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; cfg_valid = vecs[i].valid; cfg_div = vecs[i].div; cfg_high = vecs[i].high;
      step();
      check($sformatf("vec%0d clk_out", i), clk_out, vecs[i].e_clk);
      check($sformatf("vec%0d period_tick", i), period_tick, vecs[i].e_tick);
      check($sformatf("vec%0d cfg_ready", i), cfg_ready, vecs[i].e_ready);
      check($sformatf("vec%0d cfg_err", i), cfg_err, vecs[i].e_err);
    end
    cfg_valid = 1'b0;

    // Defaults: 50 high / 50 low, one tick per 100 cycles, high one cycle after en.
    do_reset();
    en = 1'b1;
    highs = 0; ticks = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i == 0) check("default first clk_out", clk_out, 1);
      if (i < 100 && clk_out) highs++;
      if (period_tick) ticks++;
    end
    check("default highs per period", highs, 50);
    check("default ticks in 200", ticks, 2);

    // Reconfigure mid-period: the running 10-cycle period completes, then 3/3.
    do_reset();
    offer(10, 5);
    en = 1'b1;
    tick_idx.delete();
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) begin
        offer(6, 3);
        check("pending cfg_ready", cfg_ready, 0);
      end else begin
        step();
      end
      if (period_tick) tick_idx.push_back(i);
      if (i >= 10 && i < 16 && clk_out) highs++;
    end
    check("ticks seen", tick_idx.size(), 5);
    if (tick_idx.size() >= 3) begin
      check("old period length", tick_idx[1] - tick_idx[0], 10);
      check("new period length", tick_idx[2] - tick_idx[1], 6);
    end
    check("new period highs", highs, 3);

    // Stop with a pending config: the pending values drive the restart.
    do_reset();
    offer(10, 5);
    en = 1'b1;
    repeat (3) step();
    offer(4, 2);
    en = 1'b0;
    step();
    check("stop clk_out", clk_out, 0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      pat[i] = clk_out;
    end
    check("restart pattern", pat, 8'b0011_0011);

    // Reset during the high phase with a pending config: back to 100/50.
    do_reset();
    offer(10, 5);
    en = 1'b1;
    repeat (2) step();
    offer(4, 2);
    step();
    do_reset();
    en = 1'b1;
    highs = 0; ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (clk_out) highs++;
      if (period_tick) ticks++;
    end
    check("post-reset highs", highs, 50);
    check("post-reset ticks", ticks, 1);

    // Largest legal divide ratio is accepted; high == div is not.
    do_reset();
    offer(64'hFFFF_FFFF, 64'hFFFF_FFFE);
    check("max div accepted", cfg_err, 0);
    offer(64'hFFFF_FFFF, 64'hFFFF_FFFF);
    check("high==div rejected", cfg_err, 1);
    en = 1'b1;
    repeat (5) step();

`ifdef CLK_DIV_RESYNC_EN
    do_reset();
    offer(10, 5);
    en = 1'b1;
    repeat (4) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync tick", period_tick, 1);
    check("resync clk_out", clk_out, 1);
    repeat (12) step();
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 39) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = W'($urandom_range(0, 12));
      cfg_high  = W'($urandom_range(0, 12));
`ifdef CLK_DIV_RESYNC_EN
      resync    = ($urandom_range(0, 29) == 0);
`endif
      step();
    end
    cfg_valid = 1'b0;
    resync = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
